pwm_duty_generator: RTL and testbench



---
 rtl/pwm_duty_generator.sv | 136 +++++++++++++
 tb/tb_pwm_duty_generator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_generator.sv
// PWM generator locked to a selectable divider carrier.
// Measures the carrier period and emits a duty-scaled pulse per period.
module pwm_duty_generator #(
    parameter int CNT_W  = 12,
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        freq_in,
    input  logic [2:0]        freq_sel,
    input  logic [DUTY_W-1:0] duty,
    input  logic              enable,
    output logic              pwm_out,
    output logic              period_valid,
    output logic [CNT_W-1:0]  period_len
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQ,
        S_MEAS,
        S_RUN
    } state_t;

    localparam int PROD_W = CNT_W + DUTY_W;

    state_t              state_q, state_d;
    logic [2:0]          sel_q, sel_d;
    logic                car_d_q, car_d_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pwm_q, pwm_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    plen_q, plen_d;
    logic [DUTY_W-1:0]   duty_l_q, duty_l_d;
    logic [CNT_W-1:0]    thr_q, thr_d;

    logic                car;
    logic                rise;
    logic                sel_chg;
    logic                ovf;
    logic [CNT_W-1:0]    per_new;
    logic [PROD_W-1:0]   prod;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            car_d_q  <= 1'b0;
            cnt_q    <= '0;
            pwm_q    <= 1'b0;
            valid_q  <= 1'b0;
            plen_q   <= '0;
            duty_l_q <= '0;
            thr_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            car_d_q  <= car_d_d;
            cnt_q    <= cnt_d;
            pwm_q    <= pwm_d;
            valid_q  <= valid_d;
            plen_q   <= plen_d;
            duty_l_q <= duty_l_d;
            thr_q    <= thr_d;
        end
    end

    // Edge detect, period measurement, threshold and next-state logic
    always_comb begin
        car     = freq_in[sel_q];
        rise    = car & ~car_d_q;
        sel_chg = (freq_sel != sel_q);
        ovf     = (cnt_q == {CNT_W{1'b1}}) & ~rise;
        per_new = cnt_q + 1'b1;
        prod    = PROD_W'(per_new) * PROD_W'(duty);

        state_d  = state_q;
        sel_d    = freq_sel;
        car_d_d  = car;
        cnt_d    = rise ? '0 : cnt_q + 1'b1;
        valid_d  = valid_q;
        plen_d   = plen_q;
        duty_l_d = duty_l_q;
        thr_d    = thr_q;

        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else if (sel_chg) begin
            // Preload the edge detector from the new carrier: no false edge
            state_d = S_ACQ;
            cnt_d   = '0;
            valid_d = 1'b0;
            car_d_d = freq_in[freq_sel];
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_ACQ;
                    cnt_d   = '0;
                end
                S_ACQ: begin
                    if (rise) begin
                        state_d = S_MEAS;
                    end else if (ovf) begin
                        cnt_d = '0;
                    end
                end
                S_MEAS, S_RUN: begin
                    if (rise) begin
                        state_d  = S_RUN;
                        plen_d   = per_new;
                        valid_d  = 1'b1;
                        duty_l_d = duty;
                        thr_d    = prod[PROD_W-1:DUTY_W];
                    end else if (ovf) begin
                        state_d = S_ACQ;
                        cnt_d   = '0;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        pwm_d = (state_d == S_RUN) && (cnt_d < thr_d);
    end

    assign pwm_out      = pwm_q;
    assign period_valid = valid_q;
    assign period_len   = plen_q;

endmodule

// File: tb/tb_pwm_duty_generator.sv
// Randomised bench for pwm_duty_generator with a behavioural model.
// Carriers come from per-bit programmable square-wave generators.
module tb_pwm_duty_generator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  freq_in = '0;
    logic [2:0]  freq_sel = '0;
    logic [7:0]  duty = '0;
    logic        enable = 1'b0;
    logic        pwm_out;
    logic        period_valid;
    logic [11:0] period_len;

    int errors = 0;
    int checks = 0;
    bit checking = 0;

    int per   [8];
    int ph    [8];
    bit stuck [8];

    // model state: phase 0 = acquiring, 1 = one edge seen, 2 = running
    bit active_m;
    int phase_m;
    int since_m;
    int sel_m;
    bit prev_m;
    bit pwm_m;
    bit valid_m;
    int plen_m;
    int thr_m;

    int run_len = 0;
    int last_high = 0;
    int hi_cnt = 0;

    pwm_duty_generator #(.CNT_W(12), .DUTY_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .freq_in      (freq_in),
        .freq_sel     (freq_sel),
        .duty         (duty),
        .enable       (enable),
        .pwm_out      (pwm_out),
        .period_valid (period_valid),
        .period_len   (period_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors < 30)
                $display("FAIL %s: got %0d expected %0d at %0t",
                         nm, act, exp, $time);
        end
    endtask

    // square-wave carriers, high for the first half of each period
    always @(negedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (!stuck[i]) begin
                ph[i] = (ph[i] + 1 >= per[i]) ? 0 : ph[i] + 1;
                freq_in[i] = (ph[i] < per[i] / 2);
            end
        end
    end

    // behavioural model: tracks edges and elapsed cycles since the last one
    always @(posedge clk) begin
        bit car;
        bit edge_s;
        car = freq_in[sel_m];
        edge_s = car && !prev_m;
        if (rst) begin
            active_m = 0; phase_m = 0; since_m = 0; sel_m = 0;
            prev_m = 0; valid_m = 0; plen_m = 0; thr_m = 0;
        end else begin
            if (!enable) begin
                active_m = 0; phase_m = 0; since_m = 0;
                valid_m = 0; prev_m = car;
            end else if (int'(freq_sel) != sel_m) begin
                active_m = 1; phase_m = 0; since_m = 0;
                valid_m = 0; prev_m = freq_in[freq_sel];
            end else if (!active_m) begin
                active_m = 1; phase_m = 0; since_m = 0; prev_m = car;
            end else begin
                if (edge_s) begin
                    if (phase_m >= 1) begin
                        plen_m = (since_m + 1) % 4096;
                        valid_m = 1;
                        thr_m = (plen_m * int'(duty)) / 256;
                        phase_m = 2;
                    end else begin
                        phase_m = 1;
                    end
                    since_m = 0;
                end else if (since_m == 4095) begin
                    phase_m = 0; valid_m = 0; since_m = 0;
                end else begin
                    since_m++;
                end
                prev_m = car;
            end
            sel_m = int'(freq_sel);
        end
        pwm_m = (phase_m == 2) && (since_m < thr_m);
    end

    // per-cycle comparison plus pulse-width monitor
    always @(negedge clk) begin
        if (checking) begin
            check("pwm_out", int'(pwm_out), int'(pwm_m));
            check("period_valid", int'(period_valid), int'(valid_m));
            check("period_len", int'(period_len), plen_m);
        end
        if (pwm_out === 1'b1) begin
            run_len++;
            hi_cnt++;
        end else if (run_len > 0) begin
            last_high = run_len;
            run_len = 0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            per[i] = 4 + 3 * i;
            ph[i] = i;
            stuck[i] = 0;
        end
        per[0] = 10;
        per[3] = 14;
        cyc(3);
        rst = 1'b0;
        checking = 1;
        cyc(1);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_valid", int'(period_valid), 0);
        check("rst_plen", int'(period_len), 0);

        // basic 50% duty on a 10-cycle carrier
        duty = 8'd128;
        enable = 1'b1;
        cyc(60);
        check("plen10", int'(period_len), 10);
        check("model_plen10", plen_m, 10);
        check("model_thr5", thr_m, 5);
        check("high5", last_high, 5);

        // zero and near-full duty
        duty = 8'd0;
        cyc(25);
        hi_cnt = 0;
        cyc(30);
        check("duty0_high", hi_cnt, 0);
        duty = 8'd255;
        cyc(40);
        check("high9", last_high, 9);
        cyc(3);
        duty = 8'd64;
        cyc(30);
        check("high2", last_high, 2);

        // select change mid-period
        duty = 8'd128;
        cyc(14);
        freq_sel = 3'd3;
        cyc(1);
        check("selchg_pwm", int'(pwm_out), 0);
        check("selchg_valid", int'(period_valid), 0);
        cyc(50);
        check("plen14", int'(period_len), 14);

        // stuck carrier overflow
        stuck[3] = 1;
        cyc(4110);
        check("stuck_valid", int'(period_valid), 0);
        check("stuck_pwm", int'(pwm_out), 0);
        stuck[3] = 0;
        cyc(45);
        check("restart_valid", int'(period_valid), 1);
        check("restart_plen", int'(period_len), 14);

        // enable drop and reset mid-pulse
        while (pwm_out !== 1'b1 && hi_cnt < 1000000) begin
            hi_cnt += 100000;
            cyc(1);
        end
        enable = 1'b0;
        cyc(1);
        check("en_pwm", int'(pwm_out), 0);
        check("en_valid", int'(period_valid), 0);
        enable = 1'b1;
        cyc(45);
        check("reen_valid", int'(period_valid), 1);
        cyc(3);
        rst = 1'b1;
        cyc(1);
        check("rst2_pwm", int'(pwm_out), 0);
        check("rst2_valid", int'(period_valid), 0);
        rst = 1'b0;
        cyc(45);
        check("rerst_plen", int'(period_len), 14);

        // randomised operation
        for (int k = 0; k < 250; k++) begin
            duty = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0)
                freq_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 11) == 0)
                enable = ~enable;
            if ($urandom_range(0, 9) == 0)
                per[$urandom_range(0, 7)] = $urandom_range(4, 40);
            cyc($urandom_range(1, 40));
        end

        // divider-rate carrier: 25 kHz at 100 MHz
        enable = 1'b1;
        freq_sel = 3'd0;
        duty = 8'd64;
        per[0] = 4000;
        cyc(12100);
        check("plen4000", int'(period_len), 4000);
        check("high1000", last_high, 1000);

        checking = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
